p_mul_seq: RTL and testbench
============================

Name: p_mul_seq

Overview:
- Sequential packed multiplier for the XCrypto packed-arithmetic unit. Generalises the single-cycle-checked packed multiply to all five pack widths (32/16/8/4/2), carry-less mode and a configurable number of multiplier bits retired per cycle.
- Sits behind the instruction decoder on the same valid/ready handshake as the other multi-cycle packed units. Returns the packed low or high halves of the per-lane double-width products.

Parameters:
- BITS_PER_CYCLE, 4, multiplier bits consumed per iteration per lane; legal values 1, 2, 4, 8.

Ports:
- clock  input  1  system clock
- resetn  input  1  synchronous active-low reset
- valid  input  1  request valid; must be held until ready or abort
- ready  output  1  one-cycle pulse: result valid, request consumed
- mul_l  input  1  return low W bits of each lane product
- mul_h  input  1  return high W bits of each lane product
- clmul  input  1  1 = carry-less (XOR) multiply, 0 = integer unsigned multiply
- pw  input  5  one-hot pack width: [0]=32, [1]=16, [2]=8, [3]=4, [4]=2
- crs1  input  32  multiplicand, packed lanes
- crs2  input  32  multiplier, packed lanes
- result  output  32  packed result

Behaviour:
- Single clock domain. Reset is synchronous and active-low: clock port `clock`, reset port `resetn`.
- Reset: state=IDLE, ready=0, result=0, accumulator=0. Reset asserted mid-operation abandons the operation; the next cycle is IDLE with ready=0.
- Lane width W from pw, priority pw[0]>pw[1]>...>pw[4]; pw==0 decodes as W=32. 32/W lanes, lane i = bits [i*W +: W].
- Per-lane product P_i is 2W bits, using integer or carry-less multiply. Lane-unsigned.
- Output selection:
  - mul_l: result lane i = P_i[W-1:0].
  - else mul_h: result lane i = P_i[2W-1:W].
  - neither: result=0.
  - mul_l has priority when both are set.
- Operands, pw, clmul, mul_l and mul_h are captured when leaving IDLE. Later input changes have no effect.
- States:
  - IDLE: if valid=1, capture inputs, clear the 64-bit accumulator, step=0, go to RUN.
  - RUN: each cycle, every lane adds (clmul: XORs) crs1_lane * crs2_lane[step*B +: B], shifted left by step*B, into its own 2W-bit accumulator slice. No carry propagates across a 2W boundary. step++. After N=ceil(W/B) steps go to DONE. If valid=0 in any RUN cycle, go to IDLE immediately; ready is never raised.
  - DONE: ready=1 for exactly one cycle; result is updated that cycle; go to IDLE.
- Latency: ready is asserted N+1 cycles after the cycle in which valid is sampled in IDLE.
  - B=4 example: pw32 → 9 cycles; pw16 → 5; pw8 → 3; pw4 and pw2 → 2.
- result holds its last completed value until the next DONE or reset.
- Back-to-back: valid held high after the ready cycle is sampled in IDLE the following cycle and starts a new operation. Minimum spacing between ready pulses is therefore N+2 cycles.
- Integer mode keeps a full 2W-bit product per lane: 32-bit lane uses the full 64-bit accumulator, no truncation.

Decomposition:
- Shared package/include (p_pkg):
  - pw one-hot bit positions
  - lane-width decode function
  - carry-kill mask constants per pack width (64-bit, boundaries at 2W)
  - state encodings IDLE/RUN/DONE
- Sub-module p_mul_acc_add: 64-bit packed adder with a carry-kill mask input and an XOR-mode input. Instantiated once for the accumulator update. The FSM, step counter and result packing stay in p_mul_seq.

Test Plan:
- pw=32, mul_l, clmul=0, crs1=0xFFFFFFFF, crs2=0x00000002 → result=0xFFFFFFFE; ready exactly 9 cycles after start (B=4). Repeat with mul_h → 0x00000001.
- pw=8, crs1=0x0302FF10, crs2=0x0205FF10:
  - mul_l → 0x060A0100.
  - mul_h → 0x0000FE01.
  - ready 3 cycles after start.
- clmul=1:
  - pw=32, crs1=crs2=0x00000003, mul_l → 0x00000005, mul_h → 0x00000000.
  - pw=16, crs1=0x80010003, crs2=0x00020003: mul_l → 0x00020005, mul_h → 0x00010000.
- Abort: start pw=32, drop valid in the 3rd RUN cycle → no ready pulse, result unchanged. Next request (crs1=7, crs2=6, mul_l) → 0x0000002A with full latency.
- Reset mid-op: resetn=0 for one cycle during RUN → next cycle ready=0, result=0, IDLE. A subsequent request completes correctly.
- Randomised: all pw, clmul, mul_l/mul_h and all legal BITS_PER_CYCLE against a golden lane model. Back-to-back valid held high: every ready pulse matches and pulses are spaced N+2 cycles apart.

Source files
------------

// File: rtl/p_pkg.sv
// Shared definitions for the sequential packed multiplier: pack-width decode,
// per-width carry-kill masks and FSM state encoding.
package p_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned PW_W   = 5;
  localparam int unsigned STEP_W = 6;

  localparam int unsigned PW_32 = 0;
  localparam int unsigned PW_16 = 1;
  localparam int unsigned PW_8  = 2;
  localparam int unsigned PW_4  = 3;
  localparam int unsigned PW_2  = 4;

  // A set bit kills the carry out of that position (top bit of each 2W slice).
  localparam logic [ACC_W-1:0] KILL_32 = 64'h8000_0000_0000_0000;
  localparam logic [ACC_W-1:0] KILL_16 = 64'h8000_0000_8000_0000;
  localparam logic [ACC_W-1:0] KILL_8  = 64'h8000_8000_8000_8000;
  localparam logic [ACC_W-1:0] KILL_4  = 64'h8080_8080_8080_8080;
  localparam logic [ACC_W-1:0] KILL_2  = 64'h8888_8888_8888_8888;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width index 0..4 meaning W = 32 >> index; lowest set pw bit wins, zero means 32.
  function automatic logic [2:0] pw_index(input logic [PW_W-1:0] pw);
    if (pw[PW_32])      return 3'd0;
    else if (pw[PW_16]) return 3'd1;
    else if (pw[PW_8])  return 3'd2;
    else if (pw[PW_4])  return 3'd3;
    else if (pw[PW_2])  return 3'd4;
    else                return 3'd0;
  endfunction

  function automatic int unsigned lane_width(input logic [2:0] idx);
    return XLEN >> idx;
  endfunction

  function automatic logic [ACC_W-1:0] kill_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    return KILL_32;
      3'd1:    return KILL_16;
      3'd2:    return KILL_8;
      3'd3:    return KILL_4;
      3'd4:    return KILL_2;
      default: return KILL_32;
    endcase
  endfunction

  // Iterations needed to retire every multiplier bit of a lane.
  function automatic logic [STEP_W-1:0] num_steps(input logic [2:0] idx, input int unsigned b);
    return STEP_W'((lane_width(idx) + b - 1) / b);
  endfunction

endpackage

// File: rtl/p_mul_acc_add.sv
// 64-bit packed accumulator adder: carries stop at kill-mask positions,
// and xor_mode turns it into a carry-less (GF(2)) accumulate.
module p_mul_acc_add
  import p_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic [ACC_W-1:0] kill,
  input  logic             xor_mode,
  output logic [ACC_W-1:0] sum_c
);

  always_comb begin
    logic carry;
    carry = 1'b0;
    sum_c = '0;
    for (int k = 0; k < ACC_W; k++) begin
      sum_c[k] = a[k] ^ b[k] ^ carry;
      carry    = ((a[k] & b[k]) | (carry & (a[k] ^ b[k]))) & ~kill[k] & ~xor_mode;
    end
  end

endmodule

// File: rtl/p_mul_seq.sv
// Sequential packed multiplier: retires BITS_PER_CYCLE multiplier bits per lane
// per cycle into a 64-bit lane-partitioned accumulator, integer or carry-less.
module p_mul_seq
  import p_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            valid,
  output logic            ready,
  input  logic            mul_l,
  input  logic            mul_h,
  input  logic            clmul,
  input  logic [PW_W-1:0] pw,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  output logic [XLEN-1:0] result
);

  localparam int unsigned B       = BITS_PER_CYCLE;
  localparam int unsigned N_WIDTH = 5;

  state_t              state_q, state_d;
  logic [2:0]          pw_idx_q;
  logic                clmul_q, mul_l_q, mul_h_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic [ACC_W-1:0]    acc_q;
  logic [STEP_W-1:0]   step_q;

  logic                start, advance, finish;
  logic [7:0]          shift;
  logic [ACC_W-1:0]    addend, acc_sum;
  logic [XLEN-1:0]     lane_lo, lane_hi, res_sel;

  logic [N_WIDTH-1:0][ACC_W-1:0] addend_all;
  logic [N_WIDTH-1:0][XLEN-1:0]  lo_all, hi_all;

  assign shift = 8'(step_q) * 8'(B);

  // One partial-product / result-slicing datapath per pack width; the captured width picks one.
  for (genvar k = 0; k < N_WIDTH; k++) begin : g_w
    localparam int unsigned W     = XLEN >> k;
    localparam int unsigned LANES = XLEN / W;
    localparam int unsigned SW    = 2 * W;
    localparam logic [SW-1:0] CHUNK_MASK = SW'((64'd1 << B) - 64'd1);

    logic [ACC_W-1:0] addend_k;
    logic [XLEN-1:0]  lo_k, hi_k;

    always_comb begin
      logic [SW-1:0] a_ext, b_chunk, prod;
      a_ext    = '0;
      b_chunk  = '0;
      prod     = '0;
      addend_k = '0;
      lo_k     = '0;
      hi_k     = '0;
      for (int i = 0; i < LANES; i++) begin
        a_ext   = SW'(a_q[i*W +: W]);
        b_chunk = (SW'(b_q[i*W +: W]) >> shift) & CHUNK_MASK;
        prod    = '0;
        if (clmul_q) begin
          for (int j = 0; j < SW; j++) begin
            if (b_chunk[j]) prod = prod ^ (a_ext << j);
          end
        end else begin
          prod = a_ext * b_chunk;
        end
        addend_k[i*SW +: SW] = prod << shift;
        lo_k[i*W +: W]       = acc_sum[i*SW +: W];
        hi_k[i*W +: W]       = acc_sum[i*SW + W +: W];
      end
    end

    assign addend_all[k] = addend_k;
    assign lo_all[k]     = lo_k;
    assign hi_all[k]     = hi_k;
  end

  always_comb begin
    addend  = '0;
    lane_lo = '0;
    lane_hi = '0;
    case (pw_idx_q)
      3'd0: begin addend = addend_all[0]; lane_lo = lo_all[0]; lane_hi = hi_all[0]; end
      3'd1: begin addend = addend_all[1]; lane_lo = lo_all[1]; lane_hi = hi_all[1]; end
      3'd2: begin addend = addend_all[2]; lane_lo = lo_all[2]; lane_hi = hi_all[2]; end
      3'd3: begin addend = addend_all[3]; lane_lo = lo_all[3]; lane_hi = hi_all[3]; end
      3'd4: begin addend = addend_all[4]; lane_lo = lo_all[4]; lane_hi = hi_all[4]; end
      default: ;
    endcase
  end

  p_mul_acc_add u_acc_add (
    .a        (acc_q),
    .b        (addend),
    .kill     (kill_mask(pw_idx_q)),
    .xor_mode (clmul_q),
    .sum_c    (acc_sum)
  );

  assign res_sel = mul_l_q ? lane_lo : (mul_h_q ? lane_hi : '0);

  // Next-state: dropping valid during RUN abandons the operation without a ready pulse.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          start   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!valid) begin
          state_d = ST_IDLE;
        end else begin
          advance = 1'b1;
          if (step_q == num_steps(pw_idx_q, B) - STEP_W'(1)) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      pw_idx_q <= '0;
      clmul_q  <= 1'b0;
      mul_l_q  <= 1'b0;
      mul_h_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      ready    <= 1'b0;
      result   <= '0;
    end else begin
      state_q <= state_d;
      ready   <= finish;
      if (start) begin
        pw_idx_q <= pw_index(pw);
        clmul_q  <= clmul;
        mul_l_q  <= mul_l;
        mul_h_q  <= mul_h;
        a_q      <= crs1;
        b_q      <= crs2;
        acc_q    <= '0;
        step_q   <= '0;
      end
      if (advance) begin
        acc_q  <= acc_sum;
        step_q <= step_q + STEP_W'(1);
      end
      if (finish) result <= res_sel;
    end
  end

endmodule

// File: tb/tb_p_mul_seq.sv
// Directed and back-to-back random checks of p_mul_seq against a lane-level arithmetic model.
module tb_p_mul_seq;

  localparam int unsigned B = 4;

  logic        clock = 1'b0;
  logic        resetn, valid, mul_l, mul_h, clmul;
  logic [4:0]  pw;
  logic [31:0] crs1, crs2;
  logic        ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  p_mul_seq #(.BITS_PER_CYCLE(B)) dut (
    .clock  (clock),
    .resetn (resetn),
    .valid  (valid),
    .ready  (ready),
    .mul_l  (mul_l),
    .mul_h  (mul_h),
    .clmul  (clmul),
    .pw     (pw),
    .crs1   (crs1),
    .crs2   (crs2),
    .result (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned tb_width(input logic [4:0] p);
    if (p[0]) return 32;
    if (p[1]) return 16;
    if (p[2]) return 8;
    if (p[3]) return 4;
    if (p[4]) return 2;
    return 32;
  endfunction

  function automatic int unsigned tb_steps(input logic [4:0] p);
    return (tb_width(p) + B - 1) / B;
  endfunction

  function automatic logic [31:0] gold(input logic [4:0] p, input logic c, input logic l,
                                       input logic h, input logic [31:0] a, input logic [31:0] b);
    int unsigned     w;
    longint unsigned msk;
    logic [31:0]     r;
    w   = tb_width(p);
    msk = (64'd1 << w) - 64'd1;
    r   = '0;
    for (int unsigned i = 0; i < 32 / w; i++) begin
      longint unsigned la, lb, prod, sel;
      la   = (64'(a) >> (i * w)) & msk;
      lb   = (64'(b) >> (i * w)) & msk;
      prod = 0;
      sel  = 0;
      if (c) begin
        for (int unsigned j = 0; j < w; j++) begin
          if (((lb >> j) & 64'd1) != 0) prod = prod ^ (la << j);
        end
      end else begin
        prod = la * lb;
      end
      if (l) sel = prod & msk;
      else if (h) sel = (prod >> w) & msk;
      r = r | 32'(sel << (i * w));
    end
    return r;
  endfunction

  // Reference model: request-level timing (N RUN cycles then one DONE cycle).
  bit          m_busy = 1'b0, m_done = 1'b0, exp_ready = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0, exp_result = '0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_busy = 1'b0; m_done = 1'b0; exp_ready = 1'b0; exp_result = '0;
    end else if (m_done) begin
      m_done = 1'b0; exp_ready = 1'b0;
    end else if (m_busy) begin
      exp_ready = 1'b0;
      if (!valid) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; exp_ready = 1'b1; exp_result = m_res;
        end
      end
    end else begin
      exp_ready = 1'b0;
      if (valid) begin
        m_busy = 1'b1;
        m_left = int'(tb_steps(pw));
        m_res  = gold(pw, clmul, mul_l, mul_h, crs1, crs2);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_ready", 32'(ready), 32'(exp_ready));
      check("cyc_result", result, exp_result);
    end
  end

  task automatic do_req(input string name, input logic [4:0] p, input logic c, input logic l,
                        input logic h, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit got;
    @(negedge clock);
    pw = p; clmul = c; mul_l = l; mul_h = h; crs1 = a; crs2 = b; valid = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      got = ready;
    end
    valid = 1'b0;
    check({name, "_done"}, 32'(got), 32'd1);
    check({name, "_res"}, result, exp_res);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int          lat, exp_gap;
    bit          got, seen;
    int unsigned sel;
    logic [4:0]  p;

    resetn = 1'b0; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0; clmul = 1'b0;
    pw = '0; crs1 = '0; crs2 = '0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", result, 32'd0);
    resetn = 1'b1;

    do_req("w32_l",   5'b00001, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 9);
    do_req("w32_h",   5'b00001, 0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 9);
    do_req("w8_l",    5'b00100, 0, 1, 0, 32'h0302_FF10, 32'h0205_FF10, 32'h060A_0100, 3);
    do_req("w8_h",    5'b00100, 0, 0, 1, 32'h0302_FF10, 32'h0205_FF10, 32'h0000_FE01, 3);
    do_req("cl32_l",  5'b00001, 1, 1, 0, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005, 9);
    do_req("cl32_h",  5'b00001, 1, 0, 1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 9);
    do_req("cl16_l",  5'b00010, 1, 1, 0, 32'h8001_0003, 32'h0002_0003, 32'h0002_0005, 5);
    do_req("cl16_h",  5'b00010, 1, 0, 1, 32'h8001_0003, 32'h0002_0003, 32'h0001_0000, 5);

    // Abort in the third RUN cycle: no ready, result retained.
    @(negedge clock);
    pw = 5'b00001; clmul = 1'b0; mul_l = 1'b1; mul_h = 1'b0;
    crs1 = 32'h0000_1234; crs2 = 32'h0000_5678; valid = 1'b1;
    repeat (3) @(negedge clock);
    valid = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (ready) seen = 1'b1;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_hold", result, 32'h0001_0000);
    do_req("after_abort", 5'b00001, 0, 1, 0, 32'd7, 32'd6, 32'h0000_002A, 9);

    do_req("w4_l",    5'b01000, 0, 1, 0, 32'h0000_00F3, 32'h0000_0025, 32'h0000_00EF, 2);
    do_req("w2_h",    5'b10000, 0, 0, 1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0002, 2);
    do_req("nosel",   5'b00010, 0, 0, 0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5);
    do_req("both_l",  5'b00100, 0, 1, 1, 32'h0302_FF10, 32'h0205_FF10, 32'h060A_0100, 3);
    do_req("pw_zero", 5'b00000, 0, 0, 1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 9);
    do_req("pw_prio", 5'b10110, 0, 1, 0, 32'h8001_0003, 32'h0002_0003, 32'h0002_0009, 5);

    // Reset asserted for one cycle mid-operation.
    @(negedge clock);
    pw = 5'b00001; clmul = 1'b0; mul_l = 1'b1; mul_h = 1'b0;
    crs1 = 32'hDEAD_BEEF; crs2 = 32'h0000_0101; valid = 1'b1;
    repeat (3) @(negedge clock);
    resetn = 1'b0; valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_result", result, 32'd0);
    do_req("after_rst", 5'b00100, 0, 1, 0, 32'h0302_FF10, 32'h0205_FF10, 32'h060A_0100, 3);

    // Back-to-back with valid held: new operands presented in each ready cycle.
    @(negedge clock);
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 6);
      if (sel < 5) p = 5'(1 << sel);
      else if (sel == 5) p = '0;
      else p = 5'($urandom);
      pw = p;
      clmul = 1'($urandom);
      {mul_l, mul_h} = 2'($urandom);
      crs1 = $urandom;
      crs2 = $urandom;
      valid = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
        @(negedge clock);
        lat++;
        got = ready;
      end
      exp_gap = int'(tb_steps(p)) + ((r == 0) ? 1 : 2);
      check("b2b_gap", 32'(lat), 32'(exp_gap));
    end
    valid = 1'b0;
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
